// File: rtl/lift_pkg.sv
// Shared definitions for the lift scheduling controller: state codes and
// one-hot floor helpers used by both the scheduler and the FSM.
package lift_pkg;

   localparam int N_FLOORS_DEF = 6;
   localparam int MAX_FLOORS   = 32;

   typedef logic [2:0] lift_state_t;

   localparam lift_state_t ST_IDLE       = 3'd0;
   localparam lift_state_t ST_MOVE_UP    = 3'd1;
   localparam lift_state_t ST_MOVE_DN    = 3'd2;
   localparam lift_state_t ST_DOOR_OPEN  = 3'd3;
   localparam lift_state_t ST_DOOR_HOLD  = 3'd4;
   localparam lift_state_t ST_DOOR_CLOSE = 3'd5;
   localparam lift_state_t ST_FAULT      = 3'd6;

   typedef logic [MAX_FLOORS-1:0] floor_vec_t;

   function automatic logic is_onehot(input floor_vec_t v);
      return (v != '0) && ((v & (v - floor_vec_t'(1))) == '0);
   endfunction

   // For a one-hot position, every bit strictly above it; zero input gives zero.
   function automatic floor_vec_t above_mask(input floor_vec_t s);
      return ~((s - floor_vec_t'(1)) | s);
   endfunction

   function automatic floor_vec_t below_mask(input floor_vec_t s);
      return (s == '0) ? '0 : (s - floor_vec_t'(1));
   endfunction

endpackage

// File: rtl/lift_req_sched.sv
// Combinational SCAN request evaluator: looks at the pending set relative to
// the current floor and direction and reports what the FSM may do next.
module lift_req_sched
   import lift_pkg::*;
#(
   parameter int N_FLOORS = N_FLOORS_DEF
)(
   input  logic [N_FLOORS-1:0] pending,
   input  logic [N_FLOORS-1:0] sensor,
   input  logic                dir_up,
   output logic                hit_here,
   output logic                want_up,
   output logic                want_dn,
   output logic                reverse
);

   floor_vec_t pendWide;
   floor_vec_t sensWide;
   floor_vec_t aboveWide;
   floor_vec_t belowWide;
   logic       reqAbove;
   logic       reqBelow;

   always_comb begin
      pendWide                 = '0;
      sensWide                 = '0;
      pendWide[N_FLOORS-1:0]   = pending;
      sensWide[N_FLOORS-1:0]   = sensor;
      aboveWide                = above_mask(sensWide);
      belowWide                = below_mask(sensWide);
   end

   assign reqAbove = |(pendWide & aboveWide);
   assign reqBelow = |(pendWide & belowWide);
   assign hit_here = |(pendWide & sensWide);
   assign want_up  = dir_up & reqAbove;
   assign want_dn  = ~dir_up & reqBelow;

   // Work exists only behind us: the FSM flips direction and re-decides.
   assign reverse  = ~hit_here & ~want_up & ~want_dn &
                     (dir_up ? reqBelow : reqAbove);

endmodule

// File: rtl/lift_controller.sv
// SCAN scheduling FSM for the single-lift datapath: pending-request register,
// one-floor move commands, door sequencing, watchdog and sensor sanity fault.
module lift_controller
   import lift_pkg::*;
#(
   parameter int N_FLOORS     = N_FLOORS_DEF,
   parameter int DOOR_HOLD    = 8,
   parameter int MOVE_TIMEOUT = 255
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [N_FLOORS-1:0] call_req,
   input  logic [N_FLOORS-1:0] sensor,
   input  logic                passenger_in,
   output logic                move_up,
   output logic                move_down,
   output logic                open_door,
   output logic                close_door,
   output logic                stop,
   output logic [N_FLOORS-1:0] pending,
   output logic                dir_up,
   output logic                busy,
   output logic                fault
);

   localparam int HOLD_W = $clog2(DOOR_HOLD + 1);
   localparam int WD_W   = $clog2(MOVE_TIMEOUT + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DOOR_HOLD - 1);
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(MOVE_TIMEOUT - 1);

   lift_state_t         state_q, state_d;
   logic [N_FLOORS-1:0] pending_q, pending_d;
   logic                dir_up_q, dir_up_d;
   logic [N_FLOORS-1:0] sensor_lat_q, sensor_lat_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
   logic                move_up_q, move_down_q, open_door_q, close_door_q;
   logic                stop_q, busy_q, fault_q;

   logic [N_FLOORS-1:0] clearMask;
   floor_vec_t          sensorWide;
   logic                sensorOk;
   logic                callHere;
   logic                hitHere, wantUp, wantDn, reverse;

   lift_req_sched #(
      .N_FLOORS (N_FLOORS)
   ) u_sched (
      .pending  (pending_q),
      .sensor   (sensor),
      .dir_up   (dir_up_q),
      .hit_here (hitHere),
      .want_up  (wantUp),
      .want_dn  (wantDn),
      .reverse  (reverse)
   );

   always_comb begin
      sensorWide                 = '0;
      sensorWide[N_FLOORS-1:0]   = sensor;
      sensorOk                   = is_onehot(sensorWide);
   end

   assign callHere  = |(call_req & sensor);
   assign pending_d = (pending_q | call_req) & ~clearMask;

   // Next-state decision. Direction is only re-evaluated in IDLE when the
   // current floor has nothing to service, so the floor being served keeps
   // the direction it was approached with.
   always_comb begin
      state_d      = state_q;
      dir_up_d     = dir_up_q;
      sensor_lat_d = sensor_lat_q;
      hold_cnt_d   = hold_cnt_q;
      wd_cnt_d     = wd_cnt_q;
      clearMask    = '0;

      case (state_q)
         ST_IDLE: begin
            if (hitHere) begin
               state_d = ST_DOOR_OPEN;
            end else begin
               if (sensor[N_FLOORS-1]) begin
                  dir_up_d = 1'b0;
               end else if (sensor[0]) begin
                  dir_up_d = 1'b1;
               end else if (reverse) begin
                  dir_up_d = ~dir_up_q;
               end
               if (wantUp) begin
                  state_d = ST_MOVE_UP;
               end else if (wantDn) begin
                  state_d = ST_MOVE_DN;
               end
            end
         end
         ST_MOVE_UP, ST_MOVE_DN: begin
            if (sensor != sensor_lat_q) begin
               state_d = ST_IDLE;
            end else if (wd_cnt_q == WD_LAST) begin
               state_d = ST_FAULT;
            end
         end
         ST_DOOR_OPEN: begin
            if (passenger_in) begin
               state_d = ST_DOOR_HOLD;
            end else if (wd_cnt_q == WD_LAST) begin
               state_d = ST_FAULT;
            end
         end
         ST_DOOR_HOLD: begin
            if (callHere) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_DOOR_CLOSE;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_DOOR_CLOSE: begin
            clearMask = sensor;
            state_d   = ST_IDLE;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
         end
      endcase

      if (!sensorOk && state_q != ST_FAULT) begin
         state_d = ST_FAULT;
      end

      // Counters restart on every state change; the watchdog runs only while
      // waiting on the datapath.
      if (state_d != state_q) begin
         hold_cnt_d = '0;
         wd_cnt_d   = '0;
      end else if (state_q == ST_MOVE_UP || state_q == ST_MOVE_DN ||
                   state_q == ST_DOOR_OPEN) begin
         wd_cnt_d = wd_cnt_q + WD_W'(1);
      end

      if (state_q == ST_IDLE &&
          (state_d == ST_MOVE_UP || state_d == ST_MOVE_DN)) begin
         sensor_lat_d = sensor;
      end
   end

   // Command outputs are decoded from the next state so they are registered
   // and line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         dir_up_q     <= 1'b1;
         sensor_lat_q <= '0;
         hold_cnt_q   <= '0;
         wd_cnt_q     <= '0;
         move_up_q    <= 1'b0;
         move_down_q  <= 1'b0;
         open_door_q  <= 1'b0;
         close_door_q <= 1'b0;
         stop_q       <= 1'b0;
         busy_q       <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         dir_up_q     <= dir_up_d;
         sensor_lat_q <= sensor_lat_d;
         hold_cnt_q   <= hold_cnt_d;
         wd_cnt_q     <= wd_cnt_d;
         move_up_q    <= (state_d == ST_MOVE_UP);
         move_down_q  <= (state_d == ST_MOVE_DN);
         open_door_q  <= (state_d == ST_DOOR_OPEN);
         close_door_q <= (state_d == ST_DOOR_CLOSE);
         stop_q       <= (state_d == ST_DOOR_OPEN) || (state_d == ST_DOOR_CLOSE);
         busy_q       <= (state_d != ST_IDLE);
         fault_q      <= (state_d == ST_FAULT);
      end
   end

   assign move_up    = move_up_q;
   assign move_down  = move_down_q;
   assign open_door  = open_door_q;
   assign close_door = close_door_q;
   assign stop       = stop_q;
   assign pending    = pending_q;
   assign dir_up     = dir_up_q;
   assign busy       = busy_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_lift_controller.sv
// Self-checking bench for lift_controller: the bench plays the datapath and
// compares the lift's visit order against an abstract SCAN model.
`timescale 1ns/1ps
module tb_lift_controller;

   localparam int NF      = 6;
   localparam int HOLD    = 8;
   localparam int TIMEOUT = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NF-1:0] call_req = '0;
   logic [NF-1:0] sensor = 6'b000001;
   logic          passenger_in = 1'b0;
   logic          move_up, move_down, open_door, close_door, stop;
   logic [NF-1:0] pending;
   logic          dir_up, busy, fault;

   int assertCount = 0;
   int failCount   = 0;
   int curFloor    = 0;
   int expVisit[$];
   bit expDir[$];
   int expMoves;

   lift_controller #(
      .N_FLOORS     (NF),
      .DOOR_HOLD    (HOLD),
      .MOVE_TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .call_req     (call_req),
      .sensor       (sensor),
      .passenger_in (passenger_in),
      .move_up      (move_up),
      .move_down    (move_down),
      .open_door    (open_door),
      .close_door   (close_door),
      .stop         (stop),
      .pending      (pending),
      .dir_up       (dir_up),
      .busy         (busy),
      .fault        (fault)
   );

   always #5 clk = ~clk;

   task automatic do_reset(input int floor);
      rst          = 1'b1;
      call_req     = '0;
      passenger_in = 1'b0;
      curFloor     = floor;
      sensor       = 6'd1 << floor;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_call(input logic [NF-1:0] calls);
      call_req = calls;
      @(negedge clk);
      call_req = '0;
   endtask

   // Abstract SCAN: serve here, else keep heading the current way while work
   // lies ahead, else turn round. Boundaries force the direction.
   task automatic model_scan(input int start, input logic [NF-1:0] calls);
      bit p[NF];
      int f = start;
      bit d = 1'b1;
      int guard = 0;
      bit anyLeft, above, below;
      expVisit.delete();
      expDir.delete();
      expMoves = 0;
      for (int i = 0; i < NF; i++) p[i] = calls[i];
      if (f == NF-1) d = 1'b0;
      else if (f == 0) d = 1'b1;
      anyLeft = (calls != '0);
      while (anyLeft && guard < 200) begin
         guard++;
         if (p[f]) begin
            expVisit.push_back(f);
            expDir.push_back(d);
            p[f] = 1'b0;
         end else begin
            if (f == NF-1) d = 1'b0;
            else if (f == 0) d = 1'b1;
            above = 1'b0;
            below = 1'b0;
            for (int i = f+1; i < NF; i++) if (p[i]) above = 1'b1;
            for (int i = 0; i < f; i++) if (p[i]) below = 1'b1;
            if (d && above) begin
               f++;
               expMoves++;
            end else if (!d && below) begin
               f--;
               expMoves++;
            end else begin
               d = !d;
            end
         end
         anyLeft = 1'b0;
         for (int i = 0; i < NF; i++) if (p[i]) anyLeft = 1'b1;
      end
   endtask

   // Datapath emulation: advance the sensor on move commands after a random
   // delay, answer door opens with passenger_in, record each serviced floor.
   task automatic serve(input string tag);
      int  visited = 0;
      int  moves = 0;
      int  budget = 0;
      int  k;
      bit  goingUp;
      while (visited < expVisit.size() && budget < 3000) begin
         @(negedge clk);
         budget++;
         if (move_up || move_down) begin
            goingUp = move_up;
            assertCount++;
            if ((move_up && move_down) || (goingUp && curFloor == NF-1) ||
                (!goingUp && curFloor == 0)) begin
               failCount++;
               $display("[TB] FAIL %s move_guard: up=%0b dn=%0b floor=%0d required legal move", tag, move_up, move_down, curFloor);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (goingUp && curFloor < NF-1) curFloor++;
            else if (!goingUp && curFloor > 0) curFloor--;
            sensor = 6'd1 << curFloor;
            moves++;
            @(negedge clk);
            assertCount++;
            if (move_up !== 1'b0 || move_down !== 1'b0) begin
               failCount++;
               $display("[TB] FAIL %s move_term: up=%0b dn=%0b required 0 0", tag, move_up, move_down);
            end
         end else if (open_door) begin
            assertCount++;
            if (stop !== 1'b1) begin
               failCount++;
               $display("[TB] FAIL %s stop_open: got %0b required 1", tag, stop);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            passenger_in = 1'b1;
            k = 0;
            do begin
               @(negedge clk);
               passenger_in = 1'b0;
               k++;
            end while (close_door !== 1'b1 && k < 40);
            assertCount++;
            if (k != HOLD + 1) begin
               failCount++;
               $display("[TB] FAIL %s door_hold_len: got %0d cycles required %0d", tag, k, HOLD + 1);
            end
            assertCount++;
            if (stop !== 1'b1) begin
               failCount++;
               $display("[TB] FAIL %s stop_close: got %0b required 1", tag, stop);
            end
            assertCount++;
            if (curFloor != expVisit[visited]) begin
               failCount++;
               $display("[TB] FAIL %s visit_order[%0d]: got floor %0d required %0d", tag, visited, curFloor, expVisit[visited]);
            end
            assertCount++;
            if (dir_up !== expDir[visited]) begin
               failCount++;
               $display("[TB] FAIL %s visit_dir[%0d]: got %0b required %0b", tag, visited, dir_up, expDir[visited]);
            end
            visited++;
            @(negedge clk);
            assertCount++;
            if (close_door !== 1'b0 || pending[curFloor] !== 1'b0) begin
               failCount++;
               $display("[TB] FAIL %s close_once: close=%0b pending=%b required close 0 and floor %0d cleared", tag, close_door, pending, curFloor);
            end
         end
      end
      assertCount++;
      if (visited != expVisit.size()) begin
         failCount++;
         $display("[TB] FAIL %s service_timeout: visited %0d required %0d", tag, visited, expVisit.size());
      end
      assertCount++;
      if (moves != expMoves) begin
         failCount++;
         $display("[TB] FAIL %s move_count: got %0d required %0d", tag, moves, expMoves);
      end
      assertCount++;
      if (pending !== '0 || busy !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL %s final_idle: pending=%b busy=%0b required 0 0", tag, pending, busy);
      end
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      sensor = 6'b000001;
      repeat (2) @(posedge clk);
      @(negedge clk);
      assertCount++;
      if ({move_up, move_down, open_door, close_door, stop, busy, fault} !== 7'b0) begin
         failCount++;
         $display("[TB] FAIL reset_cmds: got %b required 0000000", {move_up, move_down, open_door, close_door, stop, busy, fault});
      end
      assertCount++;
      if (pending !== '0 || dir_up !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_regs: pending=%b dir_up=%0b required 0 1", pending, dir_up);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_call();
      do_reset(0);
      call_req = 6'b001000;
      @(negedge clk);
      call_req = '0;
      assertCount++;
      if (move_up !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL call_latency_early: move_up=%0b required 0", move_up);
      end
      @(negedge clk);
      assertCount++;
      if (move_up !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL call_latency: move_up=%0b required 1", move_up);
      end
      model_scan(0, 6'b001000);
      serve("single");
   endtask

   task automatic test_scan_order();
      do_reset(2);
      pulse_call(6'b110001);
      model_scan(2, 6'b110001);
      serve("scan");
   endtask

   task automatic test_current_floor();
      int k;
      do_reset(3);
      pulse_call(6'b001000);
      assertCount++;
      if ({move_up, move_down, open_door} !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL here_early: up/dn/open=%b required 000", {move_up, move_down, open_door});
      end
      @(negedge clk);
      assertCount++;
      if ({move_up, move_down, open_door} !== 3'b001) begin
         failCount++;
         $display("[TB] FAIL here_open: up/dn/open=%b required 001", {move_up, move_down, open_door});
      end
      passenger_in = 1'b1;
      repeat (4) begin
         @(negedge clk);
         passenger_in = 1'b0;
      end
      call_req = 6'b001000;
      k = 0;
      do begin
         @(negedge clk);
         call_req = '0;
         k++;
      end while (close_door !== 1'b1 && k < 40);
      assertCount++;
      if (k != HOLD + 1) begin
         failCount++;
         $display("[TB] FAIL hold_restart: close after %0d cycles required %0d", k, HOLD + 1);
      end
      @(negedge clk);
      assertCount++;
      if (pending !== '0 || close_door !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL hold_restart_clear: pending=%b close=%0b required 0 0", pending, close_door);
      end
   endtask

   task automatic test_boundaries();
      do_reset(5);
      @(negedge clk);
      assertCount++;
      if (dir_up !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL top_dir: got %0b required 0", dir_up);
      end
      pulse_call(6'b100000);
      @(negedge clk);
      assertCount++;
      if (move_up !== 1'b0 || open_door !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL top_call: up=%0b open=%0b required 0 1", move_up, open_door);
      end
      model_scan(5, 6'b100000);
      serve("top");
      do_reset(0);
      pulse_call(6'b000001);
      @(negedge clk);
      assertCount++;
      if (move_down !== 1'b0 || open_door !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL ground_call: dn=%0b open=%0b required 0 1", move_down, open_door);
      end
      model_scan(0, 6'b000001);
      serve("ground");
      do_reset(5);
      pulse_call(6'b100001);
      model_scan(5, 6'b100001);
      serve("top_then_ground");
   endtask

   task automatic test_random();
      int f;
      logic [NF-1:0] calls;
      for (int it = 0; it < 6; it++) begin
         f     = $urandom_range(0, NF-1);
         calls = NF'($urandom_range(1, 63));
         do_reset(f);
         pulse_call(calls);
         model_scan(f, calls);
         serve("random");
      end
   endtask

   task automatic test_watchdog();
      int i;
      do_reset(0);
      pulse_call(6'b000100);
      @(negedge clk);
      assertCount++;
      if (move_up !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL wd_move_start: move_up=%0b required 1", move_up);
      end
      i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (fault !== 1'b1 && i < 400);
      assertCount++;
      if (i != TIMEOUT) begin
         failCount++;
         $display("[TB] FAIL wd_timeout: fault after %0d cycles required %0d", i, TIMEOUT);
      end
      assertCount++;
      if ({move_up, move_down, open_door, close_door, stop, busy, fault} !== 7'b0000011) begin
         failCount++;
         $display("[TB] FAIL wd_outputs: got %b required 0000011", {move_up, move_down, open_door, close_door, stop, busy, fault});
      end
      pulse_call(6'b010000);
      assertCount++;
      if (pending !== 6'b010100) begin
         failCount++;
         $display("[TB] FAIL fault_pending: got %b required 010100", pending);
      end
   endtask

   task automatic test_invalid_sensor_reset();
      int k;
      do_reset(1);
      @(negedge clk);
      sensor = 6'b000011;
      @(negedge clk);
      sensor = 6'b000010;
      assertCount++;
      if (fault !== 1'b1 || busy !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL bad_sensor: fault=%0b busy=%0b required 1 1", fault, busy);
      end
      repeat (3) @(negedge clk);
      assertCount++;
      if (fault !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL fault_sticky: got %0b required 1", fault);
      end
      do_reset(5);
      repeat (2) @(negedge clk);
      pulse_call(6'b100000);
      k = 0;
      while (open_door !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      assertCount++;
      if (open_door !== 1'b1 || dir_up !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL pre_reset_open: open=%0b dir_up=%0b required 1 0", open_door, dir_up);
      end
      rst = 1'b1;
      @(negedge clk);
      assertCount++;
      if ({move_up, move_down, open_door, close_door, stop, busy, fault} !== 7'b0 ||
          pending !== '0 || dir_up !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL mid_door_reset: cmds=%b pending=%b dir_up=%0b required 0 0 1", {move_up, move_down, open_door, close_door, stop, busy, fault}, pending, dir_up);
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_call();
      test_scan_order();
      test_current_floor();
      test_boundaries();
      test_random();
      test_watchdog();
      test_invalid_sensor_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
